rdreg_sync_fifo: RTL and testbench
==================================

Name: rdreg_sync_fifo

Overview:
- Single-clock, first-in-first-out buffer (FIFO) with standard (non-first-word-fall-through) read timing.
- Buffers register-read return words inside the command output path:
  - one 16-bit-wide instance holds register data,
  - one 9-bit-wide instance holds register addresses.
- Both instances are written and read with identical strobes, so their empty/full flags always track each other.
- A drop-in replacement for the vendor FIFO cores, parameterised on width and depth.

Parameters:
- DATA_W, 16, data width in bits; 16 for the data instance, 9 for the address instance.
- DEPTH, 32, number of storage entries; must be a power of two ≥ 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- din  in  DATA_W  write data.
- wr_en  in  1  write strobe.
- rd_en  in  1  read strobe.
- dout  out  DATA_W  registered read data.
- full  out  1  high when DEPTH entries are stored.
- empty  out  1  high when 0 entries are stored.
- wr_rst_busy  out  1  high while the write side is in reset.
- rd_rst_busy  out  1  high while the read side is in reset.

Behaviour:
- Storage: DEPTH x DATA_W memory.
  - Write and read pointers are ADDR_W+1 bits wide; the extra bit distinguishes full from empty.
  - empty = (wptr == rptr).
  - full = (address bits equal) and (MSBs differ).
  - Both flags are driven combinationally from registered pointers, so they update the cycle after the causing strobe.
- Effective write = wr_en & !full & !wr_rst_busy.
  - Stores din at mem[wptr] and increments wptr, modulo 2*DEPTH.
- Effective read = rd_en & !empty & !rd_rst_busy.
  - On the next rising edge, dout takes mem[rptr] and rptr increments.
  - Read latency is one cycle: rd_en asserted in cycle N gives valid dout in cycle N+1.
- dout holds its last value when no effective read occurs.
- Overflow: wr_en while full is ignored; memory and pointers are unchanged and no error flag is raised.
- Underflow: rd_en while empty is ignored; dout and rptr are unchanged.
- Simultaneous strobes:
  - Empty FIFO: the write takes effect and the read is ignored; empty deasserts next cycle, and dout is not updated.
  - Full FIFO: the read takes effect and the write is ignored; full deasserts next cycle.
  - Partially filled FIFO: both take effect and the occupancy is unchanged.
- Pointer wrap-around is seamless; data order is strictly preserved across the wrap.
- Reset (synchronous, takes priority over every strobe), on the clock edge where rst=1:
  - wptr=0, rptr=0, dout=0;
  - therefore empty=1 and full=0.
- Reset busy flags:
  - wr_rst_busy and rd_rst_busy are a register that is 1 while rst is sampled high and stays 1 for one cycle after rst deasserts.
  - Power-up value of that register is 1.
- While a busy flag is high, strobes on the corresponding side are ignored.
- Reset asserted mid-operation discards all stored data; memory contents need not be cleared.

Optional Feature:
- Macro: RDREG_FIFO_DATA_COUNT_EN.
- When defined:
  - adds output data_count, ADDR_W+1 bits wide, equal to wptr-rptr (occupancy 0..DEPTH), combinational from the registered pointers;
  - data_count is 0 after reset.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst high for 2 cycles, then release.
  - Required: empty=1, full=0, dout=0, and both busy flags high until one cycle after release.
- Fill and drain: write 0x0001..0x0020 (32 words) on consecutive cycles.
  - Required: full=1 after the 32nd write.
  - Then pulse rd_en for 32 cycles: dout = 0x0001..0x0020 in order, each one cycle after its rd_en; empty=1 after the last read.
- Overflow/underflow:
  - With the FIFO full, write 0xDEAD: it is ignored, and draining yields no 0xDEAD.
  - With the FIFO empty, assert rd_en: dout holds its previous value and empty stays 1.
- Simultaneous strobes: with 5 entries stored, assert wr_en=rd_en for 10 cycles.
  - Required: occupancy stays 5, and the output sequence continues in order.
  - With the FIFO empty, wr_en=rd_en=1 with din=0x1234: empty=0 next cycle and dout unchanged; a following read returns 0x1234.
- Wrap-around: 3 rounds of writing 20 and reading 20 with DATA_W=9, using addresses 0x000..0x1FF patterns.
  - Required: all data returned in order across the pointer wrap.
- Mid-operation reset: with 10 entries stored, assert rst for 1 cycle.
  - Required: empty=1 next cycle.
  - A subsequent write of 0x0055 followed by a read returns 0x0055.

Source files
------------

// File: rtl/rdreg_sync_fifo.sv
// rdreg_sync_fifo -- single-clock FIFO with registered (non-fall-through) read
// data, used to buffer register-read return words (data and address lanes are
// two instances sharing the same strobes).
//
// Ports:
//   clk          rising-edge clock for all logic
//   rst          synchronous active-high reset (dominates every strobe)
//   din          write data
//   wr_en        write strobe (ignored when full or write side busy)
//   rd_en        read strobe (ignored when empty or read side busy)
//   dout         registered read data, valid the cycle after an accepted read
//   full         DEPTH entries stored
//   empty        no entries stored
//   wr_rst_busy  write side still recovering from reset
//   rd_rst_busy  read side still recovering from reset
//   data_count   occupancy 0..DEPTH (only when RDREG_FIFO_DATA_COUNT_EN is defined)
//
// Optional feature macro: RDREG_FIFO_DATA_COUNT_EN
module rdreg_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         din,
  input  logic                      wr_en,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         dout,
  output logic                      full,
  output logic                      empty,
`ifdef RDREG_FIFO_DATA_COUNT_EN
  output logic [$clog2(DEPTH):0]    data_count,
`endif
  output logic                      wr_rst_busy,
  output logic                      rd_rst_busy
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  // Busy stretches one cycle past reset release: rst_q remembers that reset
  // was sampled high on the previous edge. Both power up asserted so the FIFO
  // refuses traffic until the first clean cycle even without an explicit reset.
  logic rst_q   = 1'b1;
  logic busy_q  = 1'b1;
  logic busy_d;

  logic wr_fire;
  logic rd_fire;

  // Flags from registered pointers; the extra MSB separates full from empty.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
                 (wptr_q[ADDR_W] != rptr_q[ADDR_W]);

  assign wr_rst_busy = busy_q;
  assign rd_rst_busy = busy_q;

  assign wr_fire = wr_en & ~full  & ~busy_q;
  assign rd_fire = rd_en & ~empty & ~busy_q;

`ifdef RDREG_FIFO_DATA_COUNT_EN
  assign data_count = wptr_q - rptr_q;
`endif

  assign dout = dout_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    dout_d = dout_q;
    busy_d = rst | rst_q;
    if (wr_fire) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_fire) begin
      rptr_d = rptr_q + 1'b1;
      dout_d = mem_q[rptr_q[ADDR_W-1:0]];
    end
  end

  // Control and output register stage
  always_ff @(posedge clk) begin
    rst_q  <= rst;
    busy_q <= busy_d;
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      dout_q <= dout_d;
    end
  end

  // Storage array: contents survive reset; pointers alone define validity
  always_ff @(posedge clk) begin
    if (wr_fire && !rst) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= din;
    end
  end

endmodule

// File: tb/tb_rdreg_sync_fifo.sv
module tb_rdreg_sync_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] din16;
  logic [8:0]  din9;
  logic [15:0] dout16;
  logic [8:0]  dout9;
  logic        full16, empty16, wbusy16, rbusy16;
  logic        full9, empty9, wbusy9, rbusy9;
`ifdef RDREG_FIFO_DATA_COUNT_EN
  logic [5:0]  cnt16;
  logic [5:0]  cnt9;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rdreg_sync_fifo #(.DATA_W(16), .DEPTH(32)) u_data (
    .clk         (clk),
    .rst         (rst),
    .din         (din16),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .dout        (dout16),
    .full        (full16),
    .empty       (empty16),
`ifdef RDREG_FIFO_DATA_COUNT_EN
    .data_count  (cnt16),
`endif
    .wr_rst_busy (wbusy16),
    .rd_rst_busy (rbusy16)
  );

  rdreg_sync_fifo #(.DATA_W(9), .DEPTH(32)) u_addr (
    .clk         (clk),
    .rst         (rst),
    .din         (din9),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .dout        (dout9),
    .full        (full9),
    .empty       (empty9),
`ifdef RDREG_FIFO_DATA_COUNT_EN
    .data_count  (cnt9),
`endif
    .wr_rst_busy (wbusy9),
    .rd_rst_busy (rbusy9)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] addr_pat(input int idx);
    return 9'((idx * 37 + 5) % 512);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din16 = '0;
    din9  = '0;

    // Reset held two cycles
    tick();
    tick();
    chk("rst_empty", {15'd0, empty16}, 16'd1);
    chk("rst_full", {15'd0, full16}, 16'd0);
    chk("rst_dout", dout16, 16'h0000);
    chk("rst_wbusy", {15'd0, wbusy16}, 16'd1);
    chk("rst_rbusy", {15'd0, rbusy16}, 16'd1);

    // Release; a write offered during the busy window must be dropped
    rst   = 1'b0;
    wr_en = 1'b1;
    din16 = 16'h0BAD;
    din9  = 9'h0AD;
    tick();
    chk("busy_after_release", {14'd0, wbusy16, rbusy16}, 16'h0003);
    chk("busy_wr_ignored", {15'd0, empty16}, 16'd1);
    tick();
    chk("busy_cleared", {14'd0, wbusy16, rbusy16}, 16'h0000);
    chk("busy_wr_ignored2", {15'd0, empty16}, 16'd1);
    wr_en = 1'b0;

    // Fill 0x0001..0x0020
    for (int i = 1; i <= 32; i++) begin
      wr_en = 1'b1;
      din16 = 16'(i);
      din9  = 9'(i);
      tick();
      if (i == 1)  chk("fill_not_empty", {15'd0, empty16}, 16'd0);
      if (i == 31) chk("fill_not_full_31", {15'd0, full16}, 16'd0);
    end
    wr_en = 1'b0;
    chk("fill_full_32", {15'd0, full16}, 16'd1);
    chk("addr_full_tracks", {15'd0, full9}, 16'd1);
`ifdef RDREG_FIFO_DATA_COUNT_EN
    chk("fill_count", {10'd0, cnt16}, 16'd32);
`endif

    // Overflow write ignored
    wr_en = 1'b1;
    din16 = 16'hDEAD;
    din9  = 9'h1AD;
    tick();
    wr_en = 1'b0;
    chk("ovf_still_full", {15'd0, full16}, 16'd1);

    // Drain; no 0xDEAD may appear
    for (int i = 1; i <= 32; i++) begin
      rd_en = 1'b1;
      tick();
      chk($sformatf("drain_%0d", i), dout16, 16'(i));
      if (i == 1) chk("drain_not_full", {15'd0, full16}, 16'd0);
    end
    rd_en = 1'b0;
    chk("drain_empty", {15'd0, empty16}, 16'd1);
    chk("addr_empty_tracks", {15'd0, empty9}, 16'd1);
    chk("addr_last", {7'd0, dout9}, 16'h0020);
    tick();
    chk("dout_hold", dout16, 16'h0020);

    // Underflow reads ignored
    rd_en = 1'b1;
    tick();
    tick();
    rd_en = 1'b0;
    chk("udf_dout", dout16, 16'h0020);
    chk("udf_empty", {15'd0, empty16}, 16'd1);

    // Simultaneous strobes on an empty FIFO
    wr_en = 1'b1;
    rd_en = 1'b1;
    din16 = 16'h1234;
    din9  = 9'h034;
    tick();
    wr_en = 1'b0;
    chk("sim_empty_deassert", {15'd0, empty16}, 16'd0);
    chk("sim_empty_dout_hold", dout16, 16'h0020);
    tick();
    rd_en = 1'b0;
    chk("sim_empty_readback", dout16, 16'h1234);
    chk("sim_empty_after", {15'd0, empty16}, 16'd1);

    // Five entries, then ten cycles of simultaneous read+write
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      din16 = 16'h0100 + 16'(i);
      din9  = 9'(i);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      din16 = 16'h0105 + 16'(k);
      din9  = 9'(5 + k);
      tick();
      chk($sformatf("sim_part_%0d", k), dout16, 16'h0100 + 16'(k));
`ifdef RDREG_FIFO_DATA_COUNT_EN
      chk($sformatf("sim_part_cnt_%0d", k), {10'd0, cnt16}, 16'd5);
`endif
    end
    wr_en = 1'b0;
    chk("sim_part_flags", {14'd0, full16, empty16}, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      rd_en = 1'b1;
      tick();
      chk($sformatf("sim_tail_%0d", k), dout16, 16'h010A + 16'(k));
    end
    rd_en = 1'b0;
    chk("sim_tail_empty", {15'd0, empty16}, 16'd1);

    // Wrap-around: three rounds of 20 in / 20 out on both lanes
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 20; j++) begin
        wr_en = 1'b1;
        din9  = addr_pat(r * 20 + j);
        din16 = 16'hA000 + 16'(r * 20 + j);
        tick();
      end
      wr_en = 1'b0;
      for (int j = 0; j < 20; j++) begin
        rd_en = 1'b1;
        tick();
        chk($sformatf("wrap9_r%0d_%0d", r, j), {7'd0, dout9}, {7'd0, addr_pat(r * 20 + j)});
        chk($sformatf("wrap16_r%0d_%0d", r, j), dout16, 16'hA000 + 16'(r * 20 + j));
      end
      rd_en = 1'b0;
      chk($sformatf("wrap_empty_r%0d", r), {14'd0, empty9, empty16}, 16'h0003);
    end

    // Mid-operation reset with ten entries stored
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1;
      din16 = 16'h0200 + 16'(i);
      din9  = 9'(i);
      tick();
    end
    wr_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_empty", {15'd0, empty16}, 16'd1);
    chk("midrst_dout", dout16, 16'h0000);
    tick();
    tick();
    chk("midrst_busy_clear", {14'd0, wbusy16, rbusy16}, 16'h0000);
    wr_en = 1'b1;
    din16 = 16'h0055;
    din9  = 9'h055;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("midrst_readback", dout16, 16'h0055);
    chk("midrst_final_empty", {15'd0, empty16}, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
